// File: rtl/spi_master_mc_if.sv
// ============================================================================
// Module   : spi_master_mc_if
// Brief    : Request/response bus of the multi-channel SPI master.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface spi_master_mc_if #(
  parameter int DATA_W = 40,
  parameter int NCH    = 2
);
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LEN_W = $clog2(DATA_W + 1);

  logic              req_valid;
  logic              req_ready;
  logic [CHW-1:0]    req_ch;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [CHW-1:0]    rsp_ch;
  logic [DATA_W-1:0] rsp_data;

  modport slave (
    input  req_valid, req_ch, req_len, req_data,
    output req_ready, rsp_valid, rsp_ch, rsp_data
  );

  modport master (
    output req_valid, req_ch, req_len, req_data,
    input  req_ready, rsp_valid, rsp_ch, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/spi_master_mc.sv
// ============================================================================
// Module   : spi_master_mc
// Brief    : Parametrised multi-channel mode-0 SPI master, full duplex.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_master_mc #(
  parameter int DATA_W = 40,
  parameter int NCH    = 2,
  parameter int DIV    = 1,
  parameter int GAP    = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  spi_master_mc_if.slave   bus,
  output logic             busy,
  output logic             sclk,
  output logic [NCH-1:0]   cs_b,
  output logic             mosi,
  input  wire logic        miso
);
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LEN_W = $clog2(DATA_W + 1);
  localparam int DIVW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAPW  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e             state_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [CHW-1:0]     rsp_ch_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               sclk_q;
  logic [NCH-1:0]     cs_b_q;
  logic               mosi_q;
  logic [CHW-1:0]     ch_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   bit_q;
  logic [DIVW-1:0]    div_q;
  logic [GAPW-1:0]    gap_q;
  logic [DATA_W-2:0]  tx_q;   // MSB goes straight to mosi at accept
  logic [DATA_W-1:0]  rx_q;

  logic [LEN_W-1:0]   len_d;
  logic               ch_ok_d;

  // Zero and oversize lengths both run a full-width frame
  assign len_d   = ((bus.req_len == '0) || (bus.req_len > LEN_W'(DATA_W)))
                   ? LEN_W'(DATA_W) : bus.req_len;
  assign ch_ok_d = (32'(bus.req_ch) < NCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ch_q    <= '0;
      rsp_data_q  <= '0;
      sclk_q      <= 1'b0;
      cs_b_q      <= '1;
      mosi_q      <= 1'b0;
      ch_q        <= '0;
      len_q       <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q && ch_ok_d) begin
            state_q     <= S_SHIFT;
            req_ready_q <= 1'b0;
            ch_q        <= bus.req_ch;
            len_q       <= len_d;
            tx_q        <= bus.req_data[DATA_W-2:0];
            rx_q        <= '0;
            mosi_q      <= bus.req_data[DATA_W-1];
            cs_b_q      <= ~(NCH'(1) << bus.req_ch);
            sclk_q      <= 1'b0;
            div_q       <= '0;
            bit_q       <= '0;
          end
        end
        S_SHIFT: begin
          if (div_q == DIVW'(DIV - 1)) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[DATA_W-2:0], miso};
            end else if (bit_q == len_q - LEN_W'(1)) begin
              state_q     <= S_GAP;
              sclk_q      <= 1'b0;
              mosi_q      <= 1'b0;
              cs_b_q      <= '1;
              rsp_valid_q <= 1'b1;
              rsp_ch_q    <= ch_q;
              rsp_data_q  <= rx_q;
              gap_q       <= '0;
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + LEN_W'(1);
              mosi_q <= tx_q[DATA_W-2];
              tx_q   <= {tx_q[DATA_W-3:0], 1'b0};
            end
          end else begin
            div_q <= div_q + DIVW'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAPW'(GAP - 1)) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q + GAPW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_ch    = rsp_ch_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != S_IDLE);
  assign sclk          = sclk_q;
  assign cs_b          = cs_b_q;
  assign mosi          = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_mc.sv
// ============================================================================
// Module   : tb_spi_master_mc
// Brief    : Directed self-checking bench for spi_master_mc with a response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_master_mc;
  localparam int DW = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst0_n, rst1_n;
  spi_master_mc_if #(.DATA_W(DW), .NCH(2)) if0 ();
  spi_master_mc_if #(.DATA_W(DW), .NCH(3)) if1 ();

  logic       busy0, sclk0, mosi0, miso0;
  logic [1:0] cs0;
  logic       busy1, sclk1, mosi1, miso1;
  logic [2:0] cs1;
  logic       loop0, miso_val0, miso_val1;

  assign miso0 = loop0 ? mosi0 : miso_val0;
  assign miso1 = miso_val1;

  spi_master_mc #(.DATA_W(DW), .NCH(2), .DIV(1), .GAP(2)) u0 (
    .clk(clk), .rst_n(rst0_n), .bus(if0), .busy(busy0),
    .sclk(sclk0), .cs_b(cs0), .mosi(mosi0), .miso(miso0)
  );

  spi_master_mc #(.DATA_W(DW), .NCH(3), .DIV(3), .GAP(2)) u1 (
    .clk(clk), .rst_n(rst1_n), .bus(if1), .busy(busy1),
    .sclk(sclk1), .cs_b(cs1), .mosi(mosi1), .miso(miso1)
  );

  // Probe of whichever instance the current step exercises
  int         sel = 0;
  logic [2:0] cs_s;
  logic       sclk_s, mosi_s, rsp_v_s, ready_s, busy_s;
  assign cs_s    = (sel == 0) ? {1'b1, cs0} : cs1;
  assign sclk_s  = (sel == 0) ? sclk0 : sclk1;
  assign mosi_s  = (sel == 0) ? mosi0 : mosi1;
  assign rsp_v_s = (sel == 0) ? if0.rsp_valid : if1.rsp_valid;
  assign ready_s = (sel == 0) ? if0.req_ready : if1.req_ready;
  assign busy_s  = (sel == 0) ? busy0 : busy1;

  int checks = 0;
  int errors = 0;
  int unexp  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always @(negedge clk) begin
    if (if0.rsp_valid === 1'b1) begin
      if (q0.size() == 0) unexp++;
      else begin
        e0 = q0.pop_front();
        check("rsp0_ch", 64'(if0.rsp_ch), 64'(e0.ch));
        check("rsp0_data", 64'(if0.rsp_data), 64'(e0.data));
      end
    end
    if (if1.rsp_valid === 1'b1) begin
      if (q1.size() == 0) unexp++;
      else begin
        e1 = q1.pop_front();
        check("rsp1_ch", 64'(if1.rsp_ch), 64'(e1.ch));
        check("rsp1_data", 64'(if1.rsp_data), 64'(e1.data));
      end
    end
  end

  task automatic drive(input int s, input logic v, input int ch, input int len, input logic [DW-1:0] d);
    if (s == 0) begin
      if0.req_valid = v; if0.req_ch = 1'(ch); if0.req_len = 6'(len); if0.req_data = d;
    end else begin
      if1.req_valid = v; if1.req_ch = 2'(ch); if1.req_len = 6'(len); if1.req_data = d;
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ready_s === 1'b1) break;
    end
    check({tag, "_ready"}, 64'(ready_s), 64'd1);
  endtask

  task automatic run_frame(input int s, input int ch, input int len, input logic [DW-1:0] data,
                           input logic [DW-1:0] exp_rsp, input int exp_low, input int exp_rises,
                           input string tag, output logic [7:0] mseq);
    int   low, other, rises;
    logic prev, done;
    exp_t e;
    e.ch = 2'(ch);
    e.data = exp_rsp;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    wait_ready(tag);
    drive(s, 1'b1, ch, len, data);
    @(posedge clk);
    #1 drive(s, 1'b0, 0, 0, '0);
    low = 0; other = 0; rises = 0; prev = 1'b0; done = 1'b0; mseq = '0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check({tag, "_first_mosi"}, 64'(mosi_s), 64'(data[DW-1]));
        check({tag, "_busy"}, 64'(busy_s), 64'd1);
        check({tag, "_ready_low"}, 64'(ready_s), 64'd0);
      end
      if (cs_s[ch] == 1'b0) low++;
      for (int j = 0; j < 3; j++) if (j != ch && cs_s[j] == 1'b0) other++;
      if (sclk_s && !prev) begin
        rises++;
        mseq = {mseq[6:0], mosi_s};
      end
      prev = sclk_s;
      if (rsp_v_s === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cs_low_cycles"}, 64'(low), 64'(exp_low));
    check({tag, "_sclk_rises"}, 64'(rises), 64'(exp_rises));
    check({tag, "_other_cs"}, 64'(other), 64'd0);
    check({tag, "_end_lines"}, {61'd0, cs_s[ch], sclk_s, mosi_s}, 64'b100);
  endtask

  logic [7:0] ms;
  int         acc1, acc2, high, act, rdy_low, rises;
  logic       seen, prev;

  initial begin
    drive(0, 1'b0, 0, 0, '0);
    drive(1, 1'b0, 0, 0, '0);
    loop0 = 1'b0; miso_val0 = 1'b0; miso_val1 = 1'b0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    #12;
    check("rst_ready", 64'(if0.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(if0.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(if0.rsp_data), 64'd0);
    check("rst_rsp_ch", 64'(if0.rsp_ch), 64'd0);
    check("rst_lines0", {59'd0, busy0, sclk0, mosi0, cs0}, 64'b00011);
    check("rst_cs1", 64'(cs1), 64'h7);
    @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready0", 64'(if0.req_ready), 64'd1);
    check("rst_release_ready1", 64'(if1.req_ready), 64'd1);

    // Full-width loopback frame
    sel = 0; loop0 = 1'b1;
    run_frame(0, 0, 40, 40'hA512345678, 40'hA512345678, 80, 40, "t1", ms);

    // Short frame on channel 1, slower SCLK, MISO held high
    sel = 1; miso_val1 = 1'b1;
    run_frame(1, 1, 8, 40'hC300000000, 40'h00000000FF, 48, 8, "t2", ms);
    check("t2_mosi_seq", 64'(ms), 64'hC3);

    // Out-of-range channel is swallowed
    wait_ready("t5");
    drive(1, 1'b1, 3, 8, 40'hFFFFFFFFFF);
    @(posedge clk);
    #1 drive(1, 1'b0, 0, 0, '0);
    act = 0; rdy_low = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (cs_s !== 3'b111 || busy_s !== 1'b0) act++;
      if (ready_s !== 1'b1) rdy_low++;
    end
    check("t5_no_activity", 64'(act), 64'd0);
    check("t5_ready_stays", 64'(rdy_low), 64'd0);

    // Zero and oversize lengths both run full-width frames
    sel = 0; loop0 = 1'b1;
    run_frame(0, 1, 0, 40'h0123456789, 40'h0123456789, 80, 40, "t6a", ms);
    run_frame(0, 0, 63, 40'hFEDCBA9876, 40'hFEDCBA9876, 80, 40, "t6b", ms);

    // Back-to-back requests with valid held high
    e0.ch = 2'd1; e0.data = 40'h5;
    q0.push_back(e0); q0.push_back(e0);
    wait_ready("t3");
    acc1 = cyc + 1;
    acc2 = 0; high = 0; seen = 1'b0;
    drive(0, 1'b1, 1, 4, 40'h5A00000000);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rsp_v_s === 1'b1) seen = 1'b1;
      if (seen && cs_s == 3'b111) high++;
      if (seen && ready_s === 1'b1 && if0.req_valid === 1'b1) begin
        acc2 = cyc + 1;
        @(posedge clk);
        #1 drive(0, 1'b0, 0, 0, '0);
        break;
      end
    end
    check("t3_accept_spacing", 64'(acc2 - acc1), 64'd11);
    check("t3_cs_high_min", 64'(high >= 3), 64'd1);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q0.size() == 0 && busy0 === 1'b0) break;
    end
    check("t3_both_done", 64'(q0.size()), 64'd0);

    // Reset in the middle of a frame
    loop0 = 1'b0; miso_val0 = 1'b1;
    wait_ready("t4");
    drive(0, 1'b1, 0, 40, 40'hFFFF00FFFF);
    @(posedge clk);
    #1 drive(0, 1'b0, 0, 0, '0);
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sclk_s && !prev) rises++;
      prev = sclk_s;
      if (rises == 10) break;
    end
    check("t4_reached_bit10", 64'(rises), 64'd10);
    #2 rst0_n = 1'b0;
    #1;
    check("t4_rst_lines", {59'd0, busy0, sclk0, mosi0, cs0}, 64'b00011);
    check("t4_rst_ready", 64'(if0.req_ready), 64'd0);
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    check("t4_ready_after_release", 64'(if0.req_ready), 64'd1);

    repeat (5) @(negedge clk);
    check("no_unexpected_rsp", 64'(unexp), 64'd0);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_master_mc.md
# spi_master_mc

Parametrised multi-channel SPI master replacing the fixed two-target (config/DAC) SPI controller in the electrochemical front-end control path. It accepts frames through a valid/ready request port, drives one of NCH chip selects, and shifts a per-request number of bits (1..DATA_W) at a programmable SCLK rate. Every frame is full duplex, and each completed frame returns its captured MISO word on a one-cycle response strobe.

## Interface
- DATA_W, 40: maximum frame length in bits.
- NCH, 2: number of chip selects / SPI targets.
- DIV, 1: SCLK half-period in clk cycles, ≥1.
- GAP, 2: idle clk cycles with all cs_b high between frames, ≥1.
- Derived: CHW = max(1, clog2(NCH)), LEN_W = clog2(DATA_W+1).

- clk  in  1  system clock. One clock domain; all state updates on posedge clk.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_ch  in  CHW  target chip-select index.
- req_len  in  LEN_W  frame length in bits.
- req_data  in  DATA_W  TX word, MSB-aligned; the first bit sent is req_data[DATA_W-1].
- rsp_valid  out  1  one-cycle pulse, frame complete.
- rsp_ch  out  CHW  channel of the completed frame.
- rsp_data  out  DATA_W  RX word, right-aligned and zero-extended.
- busy  out  1  frame or gap in progress.
- sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- cs_b  out  NCH  active-low chip selects; at most one is low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in, sampled directly with no synchroniser.

## Operation
- States: IDLE, SHIFT, GAP.
- Reset values (async, immediate on rst_n low): state=IDLE, req_ready=0, rsp_valid=0, rsp_ch=0, rsp_data=0, busy=0, sclk=0, cs_b=all 1, mosi=0.
- Reset asserted mid-frame aborts the frame immediately. No response is produced.
- IDLE: req_ready=1 (registered; rises on the first clk edge after rst_n deasserts).
- Accept occurs when req_valid && req_ready at a clk edge.
  - Valid req_ch (< NCH): latch the channel, length and data, and move to SHIFT.
  - req_ch ≥ NCH: the request is accepted and discarded. No frame, no response; state stays IDLE.
- Length rules: req_len=0 is treated as DATA_W; req_len>DATA_W is clamped to DATA_W.
- SHIFT:
  - The addressed cs_b bit is low throughout.
  - sclk toggles every DIV clk cycles.
  - mosi updates on each sclk falling edge.
  - miso is sampled and shifted into the RX register (LSB in) on the clk edge that drives sclk high.
  - After the len-th falling edge: all cs_b go high, sclk=0, mosi=0, rsp_valid pulses, and the state moves to GAP.
- GAP: hold for GAP cycles, then return to IDLE (req_ready=1).
- busy = (state != IDLE).
- rsp_data: the first received bit lands at position len-1, the last at bit 0; bits above len-1 are 0. rsp_data holds its value until the next completion. There is no response backpressure.
- req_* inputs are ignored outside the accept edge.

## Timing
Let E0 be the accept edge and L the effective length.
- After E0:
  - cs_b[ch]=0, sclk=0, mosi=req_data[DATA_W-1], req_ready=0, busy=1.
- Bit k (1..L):
  - sclk rises at E0+(2k-1)·DIV; miso is sampled at that same edge.
  - sclk falls at E0+2k·DIV; mosi advances to data bit DATA_W-1-k.
- At E0+2L·DIV:
  - cs_b all high, sclk=0, mosi=0.
  - rsp_valid=1 for exactly one cycle, with rsp_data and rsp_ch valid in the same cycle.
- cs_b low duration: 2L·DIV cycles.
- req_ready rises after edge E0+2L·DIV+GAP. The earliest next accept is the following edge.
- Minimum cs_b-high time between frames: GAP+1 cycles.

## Test plan
1. DATA_W=40, DIV=1, ch0, len=40, data=0xA512345678, miso looped to mosi. Required:
   - cs_b[0] low 80 cycles.
   - 40 sclk rises.
   - rsp_data=0xA512345678, rsp_ch=0.
2. len=8, ch1, DIV=3, data=0xC3<<32, miso held 1. Required:
   - cs_b[1] low 48 cycles; cs_b[0] stays high.
   - mosi sequence 11000011.
   - rsp_data=0x00000000FF.
3. Two back-to-back requests with req_valid held high. Required:
   - The second accept occurs exactly 2L·DIV+GAP+1 edges after the first.
   - cs_b high ≥ GAP+1 cycles between frames.
4. rst_n pulsed low at bit 10 of a 40-bit frame. Required:
   - cs_b all 1, sclk=0, mosi=0 immediately.
   - No rsp_valid.
   - req_ready=1 one edge after release.
5. req_ch=NCH (invalid). Required:
   - Accepted in one cycle.
   - No cs_b activity, no rsp_valid.
   - req_ready stays 1.
6. req_len=0 and req_len=63. Required: both run 40-bit frames (80 cycles at DIV=1).
